axi_sram_bridge: RTL and testbench
==================================

AXI_SRAM_BRIDGE -- requirements
Module: axi_sram_bridge

Interface
REQ-001 SHALL have parameter MEM_AW, default 16, giving the SRAM word-address width (capacity 2^MEM_AW 32-bit words).
REQ-002 SHALL have parameter BASE, default 32'h0000_0000, giving the byte base address subtracted before decode.
REQ-003 aclk  in  1  sole clock; all state SHALL change on its rising edge.
REQ-004 reset_n  in  1  reset, SHALL be asynchronous and active-low.
REQ-005 arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  in  4/32/4/3/2/2/4/3/1  AXI3 read-address channel; arready  out  1.
REQ-006 rid/rdata/rresp/rlast/rvalid  out  4/32/2/1/1  read-data channel; rready  in  1.
REQ-007 awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  in  same widths as AR; awready  out  1.
REQ-008 wid/wdata/wstrb/wlast/wvalid  in  4/32/4/1/1  write-data channel; wready  out  1.
REQ-009 bid/bresp/bvalid  out  4/2/1  write-response channel; bready  in  1.
REQ-010 mem_en  out  1  SRAM access strobe; mem_we  out  4  byte write enables; mem_addr  out  MEM_AW  word address; mem_wdata  out  32; mem_rdata  in  32, valid the cycle after a read strobe.

Function
REQ-011 The block SHALL be an AXI3 slave serving the CPU master's memory traffic with one transaction in flight; FSM states are IDLE, RD_ISSUE, RD_WAIT, RD_HOLD, WR_DATA, WR_RESP.
REQ-012 Arbitration in IDLE SHALL work as follows: if only arvalid, grant read; if only awvalid, grant write; if both, grant the opposite of the last granted type. After reset the last grant is write, so the first tie goes to read.
REQ-013 On grant, the block SHALL pulse arready (or awready) for exactly one cycle, and latch id, address, len, burst and size.
REQ-014 Read path: RD_ISSUE drives mem_en=1, mem_we=0 for one cycle -> RD_WAIT captures mem_rdata -> RD_HOLD asserts rvalid with stable rid/rdata/rresp/rlast until rready; then it advances the beat and returns to RD_ISSUE, or to IDLE after the last beat. Throughput SHALL be one beat per 3 cycles when rready is held high.
REQ-015 rlast SHALL be 1 only on beat index arlen (beats = len+1, 1..16).
REQ-016 Write path: WR_DATA asserts wready; each wvalid&&wready beat SHALL drive mem_en=1, mem_we=wstrb and mem_wdata=wdata in that same cycle. After beat index awlen, the FSM moves to WR_RESP, which holds bvalid until bready and then returns to IDLE.
REQ-017 wid and wlast SHALL be ignored; the beat count comes from awlen only.
REQ-018 Beat address update: FIXED keeps the start address; INCR adds 4 per beat, regardless of size; WRAP adds 4 and wraps within the (len+1)*4-byte aligned window, for len in {1,3,7,15}. Any other WRAP len, or burst=2'b11, SHALL be treated as INCR.
REQ-019 mem_addr SHALL equal (addr-BASE)[MEM_AW+1:2]. A beat whose (addr-BASE)>>2 is >= 2^MEM_AW is out of range: such a beat SHALL have mem_en=0 and rdata=0.
REQ-020 rresp SHALL be 2'b11 (DECERR) on an out-of-range beat and 2'b00 otherwise. bresp SHALL be 2'b11 if any beat of the burst was out of range, and 2'b00 otherwise.
REQ-021 The address arithmetic SHALL be 32-bit unsigned, with wrap at 2^32 permitted.
REQ-022 Address computation SHALL ignore arsize/awsize, lock, cache and prot; byte selection SHALL come only from wstrb.
REQ-023 arready and awready SHALL never both be 1 in the same cycle, and SHALL be 0 outside IDLE.
REQ-024 mem_en SHALL be 0 in every state other than RD_ISSUE and accepted write beats.

Reset
REQ-025 On reset_n=0, all FSM state SHALL go to IDLE immediately, regardless of the clock.
REQ-026 On reset_n=0, arready, awready, wready, rvalid, bvalid, rlast, mem_en and mem_we SHALL be 0; rid, bid, rdata, rresp, bresp and mem_addr SHALL be 0; and the last grant SHALL be write.
REQ-027 Reset asserted mid-burst SHALL abandon the burst with no further SRAM strobes or responses; the first post-reset handshake SHALL be treated as a fresh transaction.

Verification
REQ-028 Single read: AR id=3, addr=0x10, len=0 with SRAM word 4=0xDEADBEEF -> rvalid 3 cycles after the AR handshake, rdata=0xDEADBEEF, rid=3, rresp=0, rlast=1.
REQ-029 INCR write: AW len=3, addr=0x20, then 4 W beats with wstrb=4'hF -> mem_addr 8,9,10,11 with mem_we=4'hF; then one bvalid with bresp=0 and bid equal to awid.
REQ-030 WRAP read: len=3, addr=0x38 -> mem_addr sequence 14,15,12,13, with rlast on the 4th beat only.
REQ-031 Simultaneous arvalid and awvalid, held high across two transactions after reset -> read granted first, write second, with arready/awready never overlapping.
REQ-032 Out-of-range: MEM_AW=4, write addr=0x40 len=1 -> no mem_en, bresp=2'b11; read from the same address -> rdata=0, rresp=2'b11 on both beats.
REQ-033 Backpressure and reset: rready held 0 for 10 cycles -> rdata and rvalid stay stable; reset_n asserted at beat 2 of a len=7 write -> all outputs go to 0 within the same cycle and no bvalid follows.

Source files
------------

// File: rtl/axi_sram_bridge.sv
// AXI3 slave bridging single-transaction CPU traffic onto a synchronous 32-bit SRAM.
// Handshakes: a transfer happens on a rising edge where valid && ready are both 1; valid never waits on ready.
module axi_sram_bridge #(
  parameter int          MEM_AW = 16,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input  logic              aclk,
  input  logic              reset_n,
  input  logic [3:0]        arid,
  input  logic [31:0]       araddr,
  input  logic [3:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic [1:0]        arlock,
  input  logic [3:0]        arcache,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  output logic [3:0]        rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [3:0]        awid,
  input  logic [31:0]       awaddr,
  input  logic [3:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic [1:0]        awlock,
  input  logic [3:0]        awcache,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  input  logic [3:0]        wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [3:0]        bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    RD_HOLD  = 3'd3,
    WR_DATA  = 3'd4,
    WR_RESP  = 3'd5
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  id_q, len_q, beat_q;
  logic [31:0] addr_q;
  logic [1:0]  burst_q;
  logic        last_wr_q, wr_err_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  logic [31:0] offset, addr_inc, wrap_mask, addr_nx;
  logic        in_range, wrap_ok, last_beat, grant_rd, grant_wr;

  assign offset   = addr_q - BASE;
  assign in_range = (offset >> (MEM_AW + 2)) == 32'd0;
  assign addr_inc = addr_q + 32'd4;

  // WRAP is only honoured for power-of-two beat counts; everything else walks like INCR.
  assign wrap_ok   = (burst_q == 2'b10) &&
                     (len_q == 4'd1 || len_q == 4'd3 || len_q == 4'd7 || len_q == 4'd15);
  assign wrap_mask = {26'd0, len_q, 2'b11};

  always_comb begin
    addr_nx = addr_inc;
    if (burst_q == 2'b00) addr_nx = addr_q;
    else if (wrap_ok)     addr_nx = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
  end

  assign last_beat = (beat_q == len_q);
  // On a tie the type not granted last time wins.
  assign grant_rd  = arvalid && (!awvalid || last_wr_q);
  assign grant_wr  = awvalid && (!arvalid || !last_wr_q);

  always_ff @(posedge aclk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    arready   = 1'b0;
    awready   = 1'b0;
    rvalid    = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 4'h0;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    case (state)
      IDLE: begin
        if (grant_rd) begin
          arready  = 1'b1;
          state_nx = RD_ISSUE;
        end else if (grant_wr) begin
          awready  = 1'b1;
          state_nx = WR_DATA;
        end
      end
      RD_ISSUE: begin
        mem_en   = in_range;
        mem_addr = offset[MEM_AW+1:2];
        state_nx = RD_WAIT;
      end
      RD_WAIT: state_nx = RD_HOLD;
      RD_HOLD: begin
        rvalid = 1'b1;
        if (rready) state_nx = last_beat ? IDLE : RD_ISSUE;
      end
      WR_DATA: begin
        wready   = 1'b1;
        mem_addr = offset[MEM_AW+1:2];
        if (wvalid) begin
          mem_en    = in_range;
          mem_we    = in_range ? wstrb : 4'h0;
          mem_wdata = wdata;
          if (last_beat) state_nx = WR_RESP;
        end
      end
      WR_RESP: begin
        bvalid = 1'b1;
        if (bready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge reset_n) begin
    if (!reset_n) begin
      id_q      <= 4'd0;
      len_q     <= 4'd0;
      beat_q    <= 4'd0;
      addr_q    <= 32'd0;
      burst_q   <= 2'b00;
      last_wr_q <= 1'b1;
      wr_err_q  <= 1'b0;
      rdata_q   <= 32'd0;
      rresp_q   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (grant_rd) begin
            id_q      <= arid;
            addr_q    <= araddr;
            len_q     <= arlen;
            burst_q   <= arburst;
            beat_q    <= 4'd0;
            last_wr_q <= 1'b0;
          end else if (grant_wr) begin
            id_q      <= awid;
            addr_q    <= awaddr;
            len_q     <= awlen;
            burst_q   <= awburst;
            beat_q    <= 4'd0;
            last_wr_q <= 1'b1;
            wr_err_q  <= 1'b0;
          end
        end
        RD_WAIT: begin
          rdata_q <= in_range ? mem_rdata : 32'd0;
          rresp_q <= in_range ? 2'b00 : 2'b11;
        end
        RD_HOLD: begin
          if (rready) begin
            addr_q <= addr_nx;
            beat_q <= beat_q + 4'd1;
          end
        end
        WR_DATA: begin
          if (wvalid) begin
            addr_q   <= addr_nx;
            beat_q   <= beat_q + 4'd1;
            wr_err_q <= wr_err_q | ~in_range;
          end
        end
        default: ;
      endcase
    end
  end

  assign rid       = id_q;
  assign bid       = id_q;
  assign rdata     = rdata_q;
  assign rresp     = rresp_q;
  assign rlast     = (state == RD_HOLD) && last_beat;
  assign bresp     = {wr_err_q, wr_err_q};
  assign state_dbg = state;

  // Size, lock, cache, prot, wid and wlast carry no meaning for this slave.
  logic unused_inputs;
  assign unused_inputs = ^{arsize, arlock, arcache, arprot,
                           awsize, awlock, awcache, awprot, wid, wlast};

endmodule

// File: tb/tb_axi_sram_bridge.sv
// Self-checking bench for axi_sram_bridge: directed table, hand sequences, random bursts vs a burst-level model.
module tb_axi_sram_bridge;
  localparam int          MEM_AW = 4;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int          DEPTH  = 1 << MEM_AW;

  logic              aclk = 1'b0;
  logic              reset_n = 1'b1;
  logic [3:0]        arid, awid, wid, rid, bid, arlen, awlen, arcache, awcache, wstrb, mem_we;
  logic [31:0]       araddr, awaddr, wdata, rdata, mem_wdata, mem_rdata;
  logic [2:0]        arsize, awsize, arprot, awprot, state_dbg;
  logic [1:0]        arburst, awburst, arlock, awlock, rresp, bresp;
  logic              arvalid, arready, awvalid, awready, wvalid, wready, wlast;
  logic              rvalid, rready, rlast, bvalid, bready, mem_en;
  logic [MEM_AW-1:0] mem_addr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sram    [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];

  always #5 aclk = ~aclk;

  axi_sram_bridge #(.MEM_AW(MEM_AW), .BASE(BASE)) dut (
    .aclk(aclk), .reset_n(reset_n),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .state_dbg(state_dbg)
  );

  // Synchronous SRAM: read data appears the cycle after the strobe.
  always @(posedge aclk) begin
    if (mem_en) begin
      if (mem_we == 4'h0) mem_rdata <= sram[mem_addr];
      else for (int b = 0; b < 4; b++)
        if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  always @(negedge aclk) begin
    if (reset_n === 1'b1) begin
      n_checks++;
      if (arready && awready) begin
        n_fail++;
        $display("FAIL ready_overlap: arready=%0b awready=%0b, required not both 1", arready, awready);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [3:0] len,
                                            input logic [1:0] burst, input int i);
    logic [31:0] nbytes, lo;
    nbytes = (32'(len) + 32'd1) * 32'd4;
    if (burst == 2'b00) return start;
    if (burst == 2'b10 && (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15)) begin
      lo = start - (start % nbytes);
      return lo + ((start - lo + 32'(4 * i)) % nbytes);
    end
    return start + 32'(4 * i);
  endfunction

  function automatic bit in_range(input logic [31:0] a);
    return ((a - BASE) / 32'd4) < 32'(DEPTH);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'(((a - BASE) / 32'd4) % 32'(DEPTH));
  endfunction

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bounded wait expired", name);
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    arvalid = 0; awvalid = 0; wvalid = 0; rready = 0; bready = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arlock = 0; arcache = 0; arprot = 0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awlock = 0; awcache = 0; awprot = 0;
    wid = 0; wdata = 0; wstrb = 0; wlast = 0;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    reset_n = 0;
    clear_inputs();
    repeat (2) @(negedge aclk);
    reset_n = 1;
    @(posedge aclk); #1;
  endtask

  task automatic ar_go(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                       input logic [1:0] burst, output bit ok);
    int cyc;
    arid = id; araddr = addr; arlen = len; arburst = burst;
    arsize = 3'($urandom_range(0, 2)); arlock = 2'($urandom); arcache = 4'($urandom);
    arprot = 3'($urandom); arvalid = 1;
    cyc = 0;
    do begin @(negedge aclk); cyc++; end while (!arready && cyc < 20);
    ok = arready;
    if (!ok) fail_now("ar_handshake");
    @(posedge aclk); #1;
    arvalid = 0;
  endtask

  task automatic aw_go(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                       input logic [1:0] burst, output bit ok);
    int cyc;
    awid = id; awaddr = addr; awlen = len; awburst = burst;
    awsize = 3'($urandom_range(0, 2)); awlock = 2'($urandom); awcache = 4'($urandom);
    awprot = 3'($urandom); awvalid = 1;
    cyc = 0;
    do begin @(negedge aclk); cyc++; end while (!awready && cyc < 20);
    ok = awready;
    if (!ok) fail_now("aw_handshake");
    @(posedge aclk); #1;
    awvalid = 0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst, input int max_stall, output logic [1:0] resp_or,
                         output int strobes, output logic [MEM_AW-1:0] last_maddr);
    logic [31:0] a, held;
    int cyc, stall;
    bit seen, ok;
    resp_or = 2'b00; strobes = 0; last_maddr = '0; held = 0;
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, len, burst, i);
      exp_addr_q.push_back(a);
      exp_q.push_back(in_range(a) ? ref_mem[word_of(a)] : 32'd0);
    end
    ar_go(id, addr, len, burst, ok);
    if (!ok) begin exp_q.delete(); exp_addr_q.delete(); return; end
    for (int i = 0; i <= int'(len); i++) begin
      stall = $urandom_range(0, max_stall);
      seen = 0; cyc = 0;
      while (1) begin
        @(negedge aclk); cyc++;
        if (mem_en) begin
          strobes++; last_maddr = mem_addr;
          check("rd_mem_addr", 32'(mem_addr), 32'(word_of(exp_addr_q[0])));
          check("rd_strobe_in_range", 32'(in_range(exp_addr_q[0])), 32'd1);
          check("rd_mem_we", 32'(mem_we), 32'd0);
        end
        if (rvalid) begin
          if (!seen) begin
            check("rdata", rdata, exp_q[0]);
            check("rresp", 32'(rresp), in_range(exp_addr_q[0]) ? 32'd0 : 32'd3);
            check("rlast", 32'(rlast), 32'(i == int'(len)));
            check("rid", 32'(rid), 32'(id));
            resp_or |= rresp; held = rdata; seen = 1;
          end else check("rdata_stable", rdata, held);
          if (stall == 0) break;
          stall--;
        end
        if (cyc > 40) begin
          fail_now("rvalid_wait");
          exp_q.delete(); exp_addr_q.delete();
          return;
        end
      end
      rready = 1;
      @(posedge aclk); #1;
      rready = 0;
      void'(exp_q.pop_front());
      void'(exp_addr_q.pop_front());
    end
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input bit full_strb, input int max_gap,
                          output logic [1:0] bresp_o, output int strobes,
                          output logic [MEM_AW-1:0] last_maddr);
    logic [31:0] a, d;
    logic [3:0]  s;
    int cyc, gap, w;
    bit ok;
    bresp_o = 2'b00; strobes = 0; last_maddr = '0;
    aw_go(id, addr, len, burst, ok);
    if (!ok) return;
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, len, burst, i);
      gap = $urandom_range(0, max_gap);
      repeat (gap) begin
        @(negedge aclk);
        check("wr_gap_no_strobe", 32'(mem_en), 32'd0);
        @(posedge aclk); #1;
      end
      d = $urandom;
      s = full_strb ? 4'hF : 4'($urandom_range(0, 15));
      wvalid = 1; wdata = d; wstrb = s; wid = 4'($urandom); wlast = 1'($urandom);
      cyc = 0;
      do begin @(negedge aclk); cyc++; end while (!wready && cyc < 20);
      if (!wready) begin fail_now("wready_wait"); wvalid = 0; return; end
      check("wr_mem_en", 32'(mem_en), 32'(in_range(a)));
      if (in_range(a)) begin
        w = word_of(a);
        check("wr_mem_addr", 32'(mem_addr), 32'(w));
        check("wr_mem_we", 32'(mem_we), 32'(s));
        check("wr_mem_wdata", mem_wdata, d);
        strobes++; last_maddr = mem_addr;
        for (int b = 0; b < 4; b++) if (s[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
      end
      @(posedge aclk); #1;
      wvalid = 0;
    end
    cyc = 0;
    do begin @(negedge aclk); cyc++; end while (!bvalid && cyc < 20);
    if (!bvalid) begin fail_now("bvalid_wait"); return; end
    check("bid", 32'(bid), 32'(id));
    bresp_o = bresp;
    repeat ($urandom_range(0, 2)) begin
      @(negedge aclk);
      check("bvalid_hold", 32'(bvalid), 32'd1);
    end
    bready = 1;
    @(posedge aclk); #1;
    bready = 0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit                wr;
    logic [3:0]        id;
    logic [31:0]       addr;
    logic [3:0]        len;
    logic [1:0]        burst;
    int                exp_strobes;
    logic [MEM_AW-1:0] exp_last_maddr;
    logic [1:0]        exp_resp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [1:0]        resp;
    int                strobes, cyc, exp_strobes;
    logic [MEM_AW-1:0] last_maddr;
    logic [31:0]       held, d, addr;
    logic [3:0]        len;
    logic [1:0]        burst;
    bit                ok, exp_err, wr;
    int                hits[$];

    vecs[0] = '{1'b1, 4'd5,  32'h0000_0020, 4'd3, 2'b01, 4, 4'd11, 2'b00};
    vecs[1] = '{1'b0, 4'd1,  32'h0000_0038, 4'd3, 2'b10, 4, 4'd13, 2'b00};
    vecs[2] = '{1'b1, 4'd2,  32'h0000_0040, 4'd1, 2'b01, 0, 4'd0,  2'b11};
    vecs[3] = '{1'b0, 4'd2,  32'h0000_0040, 4'd1, 2'b01, 0, 4'd0,  2'b11};
    vecs[4] = '{1'b0, 4'd6,  32'h0000_0008, 4'd2, 2'b00, 3, 4'd2,  2'b00};
    vecs[5] = '{1'b1, 4'd7,  32'h0000_003C, 4'd1, 2'b11, 1, 4'd15, 2'b11};
    vecs[6] = '{1'b0, 4'd8,  32'h0000_0034, 4'd2, 2'b10, 3, 4'd15, 2'b00};
    vecs[7] = '{1'b0, 4'd9,  32'h0000_0038, 4'd3, 2'b01, 2, 4'd15, 2'b11};
    vecs[8] = '{1'b1, 4'd10, 32'hFFFF_FFFC, 4'd1, 2'b01, 1, 4'd0,  2'b11};
    vecs[9] = '{1'b1, 4'd11, 32'h0000_0030, 4'd7, 2'b10, 8, 4'd11, 2'b00};

    clear_inputs();
    for (int i = 0; i < DEPTH; i++) begin
      sram[i] = $urandom;
      ref_mem[i] = sram[i];
    end
    sram[4] = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;
    mem_rdata = 32'd0;

    // Power-on reset: every control and response output at zero.
    #1 reset_n = 0;
    @(negedge aclk);
    check("reset_ctrl", {arready, awready, wready, rvalid, bvalid, rlast, mem_en, mem_we},
          32'd0);
    check("reset_ids", {rid, bid, rresp, bresp, mem_addr}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    @(negedge aclk);
    reset_n = 1;
    @(posedge aclk); #1;

    // Single read: rvalid in the third cycle after the AR handshake.
    ar_go(4'd3, 32'h10, 4'd0, 2'b01, ok);
    @(negedge aclk);
    check("single_c1_mem_en", 32'(mem_en), 32'd1);
    check("single_c1_mem_addr", 32'(mem_addr), 32'd4);
    check("single_c1_rvalid", 32'(rvalid), 32'd0);
    @(negedge aclk);
    check("single_c2_rvalid", 32'(rvalid), 32'd0);
    @(negedge aclk);
    check("single_c3_rvalid", 32'(rvalid), 32'd1);
    check("single_rdata", rdata, 32'hDEAD_BEEF);
    check("single_rid", 32'(rid), 32'd3);
    check("single_rresp", 32'(rresp), 32'd0);
    check("single_rlast", 32'(rlast), 32'd1);
    rready = 1;
    @(posedge aclk); #1;
    rready = 0;
    @(negedge aclk);
    check("single_after_rvalid", 32'(rvalid), 32'd0);

    // Throughput with rready held high: one beat every 3 cycles.
    rready = 1;
    ar_go(4'd0, 32'h0, 4'd2, 2'b01, ok);
    for (int c = 0; c < 20; c++) begin
      @(negedge aclk);
      if (rvalid) hits.push_back(c);
    end
    rready = 0;
    check("tput_beats", 32'(hits.size()), 32'd3);
    if (hits.size() == 3) begin
      check("tput_gap0", 32'(hits[1] - hits[0]), 32'd3);
      check("tput_gap1", 32'(hits[2] - hits[1]), 32'd3);
    end
    @(posedge aclk); #1;

    foreach (vecs[i]) begin
      if (vecs[i].wr)
        do_write(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].burst, 1'b1, 1,
                 resp, strobes, last_maddr);
      else
        do_read(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].burst, 2,
                resp, strobes, last_maddr);
      check($sformatf("tbl%0d_strobes", i), 32'(strobes), 32'(vecs[i].exp_strobes));
      check($sformatf("tbl%0d_resp", i), 32'(resp), 32'(vecs[i].exp_resp));
      if (vecs[i].exp_strobes > 0)
        check($sformatf("tbl%0d_last_maddr", i), 32'(last_maddr), 32'(vecs[i].exp_last_maddr));
    end

    // Tie after reset: read first, then write, with both valids held.
    do_reset();
    arid = 4'd1; araddr = 32'h0; arlen = 4'd0; arburst = 2'b01; arvalid = 1;
    awid = 4'd2; awaddr = 32'h4; awlen = 4'd0; awburst = 2'b01; awvalid = 1;
    @(negedge aclk);
    check("tie_first_arready", 32'(arready), 32'd1);
    check("tie_first_awready", 32'(awready), 32'd0);
    @(posedge aclk); #1;
    rready = 1; cyc = 0;
    do begin
      @(negedge aclk); cyc++;
      check("tie_busy_awready", 32'(awready), 32'd0);
    end while (!rvalid && cyc < 20);
    check("tie_read_rvalid", 32'(rvalid), 32'd1);
    check("tie_read_rdata", rdata, ref_mem[0]);
    @(posedge aclk); #1;
    rready = 0;
    @(negedge aclk);
    check("tie_second_awready", 32'(awready), 32'd1);
    check("tie_second_arready", 32'(arready), 32'd0);
    @(posedge aclk); #1;
    arvalid = 0; awvalid = 0;
    d = $urandom;
    wvalid = 1; wdata = d; wstrb = 4'hF;
    @(negedge aclk);
    check("tie_write_mem_en", 32'(mem_en), 32'd1);
    check("tie_write_mem_addr", 32'(mem_addr), 32'd1);
    ref_mem[1] = d;
    @(posedge aclk); #1;
    wvalid = 0; bready = 1;
    @(negedge aclk);
    check("tie_bvalid", 32'(bvalid), 32'd1);
    check("tie_bid", 32'(bid), 32'd2);
    check("tie_bresp", 32'(bresp), 32'd0);
    @(posedge aclk); #1;
    bready = 0;

    // Backpressure: rvalid and rdata hold for 10 stalled cycles.
    ar_go(4'd12, 32'h10, 4'd0, 2'b01, ok);
    cyc = 0;
    do begin @(negedge aclk); cyc++; end while (!rvalid && cyc < 20);
    if (!rvalid) fail_now("bp_rvalid_wait");
    held = rdata;
    check("bp_rdata", rdata, ref_mem[4]);
    repeat (10) begin
      @(negedge aclk);
      check("bp_rvalid_hold", 32'(rvalid), 32'd1);
      check("bp_rdata_hold", rdata, held);
    end
    rready = 1;
    @(posedge aclk); #1;
    rready = 0;

    // Reset in beat 2 of an 8-beat write: outputs clear before the next edge.
    aw_go(4'd4, 32'h0, 4'd7, 2'b01, ok);
    for (int i = 0; i < 2; i++) begin
      d = $urandom;
      wvalid = 1; wdata = d; wstrb = 4'hF;
      @(negedge aclk);
      check("rst_wr_beat_en", 32'(mem_en), 32'd1);
      ref_mem[i] = d;
      @(posedge aclk); #1;
    end
    wdata = $urandom; wvalid = 1;
    @(negedge aclk);
    check("rst_pre_mem_en", 32'(mem_en), 32'd1);
    #2 reset_n = 0;
    #1;
    check("rst_mid_ctrl", {arready, awready, wready, rvalid, bvalid, rlast, mem_en, mem_we},
          32'd0);
    check("rst_mid_ids", {rid, bid, rresp, bresp, mem_addr}, 32'd0);
    check("rst_mid_rdata", rdata, 32'd0);
    wvalid = 0;
    repeat (2) @(negedge aclk);
    reset_n = 1;
    repeat (10) begin
      @(negedge aclk);
      check("post_rst_no_bvalid", 32'(bvalid), 32'd0);
      check("post_rst_no_strobe", 32'(mem_en), 32'd0);
    end
    @(posedge aclk); #1;
    do_read(4'd5, 32'h0, 4'd2, 2'b01, 1, resp, strobes, last_maddr);
    check("post_rst_read_strobes", 32'(strobes), 32'd3);

    // Random bursts against the model.
    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, 19)) * 32'd4;
      if ($urandom_range(0, 9) == 0) addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
      len = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      burst = 2'($urandom_range(0, 3));
      exp_err = 0; exp_strobes = 0;
      for (int i = 0; i <= int'(len); i++) begin
        if (in_range(beat_addr(addr, len, burst, i))) exp_strobes++;
        else exp_err = 1;
      end
      if (wr) do_write(4'($urandom), addr, len, burst, 1'b0, 2, resp, strobes, last_maddr);
      else    do_read(4'($urandom), addr, len, burst, 3, resp, strobes, last_maddr);
      check("rand_resp", 32'(resp), exp_err ? 32'd3 : 32'd0);
      check("rand_strobes", 32'(strobes), 32'(exp_strobes));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
